// File: rtl/regfile_scoreboard.sv
// Integer register file (2R/1W, x0 = 0) with a busy-bit scoreboard for long-latency ops.
// Optional write-back forwarding and hazard release: define REGFILE_WB_BYPASS_EN.
module regfile_scoreboard #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int AW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  input  logic            rs1_used,
  input  logic            rs2_used,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  input  logic            issue_long,
  output logic            issue_ready,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic [NREG-1:0] busy_vec
);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_next;
  logic [NREG-1:0] wb_clr;
  logic [NREG-1:0] hz_busy;
  logic            wb_en;
  logic            hazard;
  logic            issue_set;

  assign wb_en = wb_valid && (wb_addr != '0);

  always_comb begin
    wb_clr = '0;
    if (wb_en) wb_clr[wb_addr] = 1'b1;
  end

`ifdef REGFILE_WB_BYPASS_EN
  // A bit being cleared this cycle no longer blocks the dependent instruction.
  assign hz_busy = busy & ~wb_clr;
`else
  assign hz_busy = busy;
`endif

  assign hazard = (rs1_used & hz_busy[rs1_addr])
                | (rs2_used & hz_busy[rs2_addr])
                | ((issue_rd != '0) & hz_busy[issue_rd]);

  assign issue_ready = ~hazard;
  assign issue_set   = issue_valid && issue_ready && issue_long && (issue_rd != '0);
  assign busy_vec    = busy;

  // Set after clear so a same-cycle issue to the written index stays busy.
  always_comb begin
    busy_next = busy & ~wb_clr;
    if (issue_set) busy_next[issue_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (rs1_addr != '0) rs1_data = regs[rs1_addr];
    if (rs2_addr != '0) rs2_data = regs[rs2_addr];
`ifdef REGFILE_WB_BYPASS_EN
    if (rst && wb_en && (wb_addr == rs1_addr)) rs1_data = wb_data;
    if (rst && wb_en && (wb_addr == rs2_addr)) rs2_data = wb_data;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs <= '{default: '0};
      busy <= '0;
    end else begin
      if (wb_en) regs[wb_addr] <= wb_data;
      busy <= busy_next;
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard (default 32x32 and a 16x64 instance).
module tb_regfile_scoreboard;

`ifdef REGFILE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1_addr, rs2_addr, issue_rd, wb_addr;
  logic        rs1_used, rs2_used, issue_valid, issue_long, wb_valid, issue_ready;
  logic [31:0] rs1_data, rs2_data, wb_data, busy_vec;

  logic [3:0]  w_rs1_addr, w_rs2_addr, w_issue_rd, w_wb_addr;
  logic        w_rs1_used, w_rs2_used, w_issue_valid, w_issue_long, w_wb_valid, w_issue_ready;
  logic [63:0] w_rs1_data, w_rs2_data, w_wb_data;
  logic [15:0] w_busy_vec;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  regfile_scoreboard u_dut (
    .clk(clk), .rst(rst),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_used(rs1_used), .rs2_used(rs2_used),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_long(issue_long),
    .issue_ready(issue_ready),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .busy_vec(busy_vec)
  );

  regfile_scoreboard #(.XLEN(64), .NREG(16)) u_dut64 (
    .clk(clk), .rst(rst),
    .rs1_addr(w_rs1_addr), .rs2_addr(w_rs2_addr), .rs1_used(w_rs1_used), .rs2_used(w_rs2_used),
    .rs1_data(w_rs1_data), .rs2_data(w_rs2_data),
    .issue_valid(w_issue_valid), .issue_rd(w_issue_rd), .issue_long(w_issue_long),
    .issue_ready(w_issue_ready),
    .wb_valid(w_wb_valid), .wb_addr(w_wb_addr), .wb_data(w_wb_data), .busy_vec(w_busy_vec)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    rs1_addr = '0; rs2_addr = '0; rs1_used = 1'b0; rs2_used = 1'b0;
    issue_valid = 1'b0; issue_rd = '0; issue_long = 1'b0;
    wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
  endtask

  // Advance one rising edge; inputs change and checks run just after the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    idle();
    w_rs1_addr = '0; w_rs2_addr = '0; w_rs1_used = 1'b0; w_rs2_used = 1'b0;
    w_issue_valid = 1'b0; w_issue_rd = '0; w_issue_long = 1'b0;
    w_wb_valid = 1'b0; w_wb_addr = '0; w_wb_data = '0;
    #1;
    check("rst_busy", busy_vec, 0);
    check("rst_ready", issue_ready, 1);
    check("rst_rd1", rs1_data, 0);
    tick();
    rst = 1'b1;

    // plain write x5, visible next cycle (same cycle only with bypass)
    wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF; rs1_addr = 5'd5;
    #1 check("wb5_same", rs1_data, BYP ? 64'hDEADBEEF : 64'h0);
    tick(); wb_valid = 1'b0;
    #1 check("wb5_read", rs1_data, 32'hDEADBEEF);
    check("wb5_busy", busy_vec, 0);

    // write to x0 ignored
    wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'h1234; rs2_addr = 5'd0;
    tick(); wb_valid = 1'b0;
    #1 check("x0_read", rs2_data, 0);

    // RAW on long rd=7
    idle();
    issue_valid = 1'b1; issue_long = 1'b1; issue_rd = 5'd7;
    #1 check("iss7_ready", issue_ready, 1);
    tick(); idle();
    rs1_addr = 5'd7; rs1_used = 1'b1;
    #1 check("raw7_stall", issue_ready, 0);
    check("raw7_busy", busy_vec, 32'h80);
    wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'h55;
    #1 check("raw7_wb_ready", issue_ready, BYP ? 1 : 0);
    check("raw7_wb_data", rs1_data, BYP ? 64'h55 : 64'h0);
    tick(); wb_valid = 1'b0;
    #1 check("raw7_after_ready", issue_ready, 1);
    check("raw7_after_data", rs1_data, 32'h55);
    check("raw7_after_busy", busy_vec, 0);

    // WAW on rd=3
    idle();
    issue_valid = 1'b1; issue_long = 1'b1; issue_rd = 5'd3;
    tick();
    issue_long = 1'b0;
    #1 check("waw3_stall", issue_ready, 0);
    tick();
    #1 check("waw3_hold", issue_ready, 0);
    wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'h33;
    #1 check("waw3_wb_ready", issue_ready, BYP ? 1 : 0);
    tick(); wb_valid = 1'b0;
    #1 check("waw3_after", issue_ready, 1);
    check("waw3_busy", busy_vec, 0);

    // same-cycle issue and write-back to x9: set wins, data lands
    idle();
    issue_valid = 1'b1; issue_long = 1'b1; issue_rd = 5'd9;
    wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'hA;
    tick(); idle();
    rs1_addr = 5'd9;
    #1 check("x9_busy", busy_vec, 32'h200);
    check("x9_data", rs1_data, 32'hA);
    rs1_used = 1'b1;
    #1 check("x9_stall", issue_ready, 0);

    // pending x4, x6 then asynchronous reset mid-cycle
    idle();
    issue_valid = 1'b1; issue_long = 1'b1; issue_rd = 5'd4;
    tick(); issue_rd = 5'd6;
    tick(); idle();
    #1 check("pend_busy", busy_vec, 32'h250);
    rs1_addr = 5'd5; rs2_addr = 5'd9;
    #2 rst = 1'b0;
    #1 check("mid_rst_busy", busy_vec, 0);
    check("mid_rst_rd1", rs1_data, 0);
    check("mid_rst_rd2", rs2_data, 0);
    check("mid_rst_ready", issue_ready, 1);
    tick(); rst = 1'b1;
    issue_valid = 1'b1; issue_long = 1'b1; issue_rd = 5'd0;
    tick(); idle();
    #1 check("rd0_busy", busy_vec, 0);
    // in-flight write-back after reset is an untracked write
    wb_valid = 1'b1; wb_addr = 5'd4; wb_data = 32'h44; rs1_addr = 5'd4;
    tick(); wb_valid = 1'b0;
    #1 check("post_rst_wb", rs1_data, 32'h44);
    check("post_rst_busy", busy_vec, 0);

    // 16 x 64 instance
    w_wb_valid = 1'b1; w_wb_addr = 4'd15; w_wb_data = 64'hFFFF_FFFF_0000_0001;
    w_rs1_addr = 4'd15; w_rs2_addr = 4'd0;
    tick(); w_wb_valid = 1'b0;
    #1 check("w64_read", w_rs1_data, 64'hFFFF_FFFF_0000_0001);
    check("w64_x0", w_rs2_data, 0);
    w_issue_valid = 1'b1; w_issue_long = 1'b1; w_issue_rd = 4'd15;
    tick(); w_issue_valid = 1'b0; w_issue_long = 1'b0;
    #1 check("w64_busy", w_busy_vec, 16'h8000);
    check("w64_waw", w_issue_ready, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
